// File: rtl/cfg_pkg.sv
// System configuration defaults for the order-book host interface.
package cfg_pkg;
  // Must not exceed the engine ingress queue depth.
  localparam int HOST_MAX_OUTSTANDING = 4;
endpackage

// File: rtl/ob_pkg.sv
// Shared order-book types: command/response records exchanged between host and engine.
package ob_pkg;
  localparam int UID_W = 4;

  typedef logic [UID_W-1:0] uid_t;

  typedef enum logic [1:0] {
    OP_ADD    = 2'd0,
    OP_CANCEL = 2'd1,
    OP_MODIFY = 2'd2,
    OP_QUERY  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_REJECT  = 2'd1,
    ST_FILL    = 2'd2,
    ST_PARTIAL = 2'd3
  } status_e;

  typedef struct packed {
    uid_t        uid;
    op_e         op;
    logic        side;
    logic [15:0] price;
    logic [15:0] qty;
  } cmd_t;

  typedef struct packed {
    uid_t        uid;
    status_e     status;
    logic [15:0] qty;
  } rsp_t;
endpackage

// File: rtl/libv_queue.sv
// Small FIFO with speculative writes: pushed entries become poppable once committed;
// replay discards everything written since the last commit.
module libv_queue #(
  parameter int W = 8,
  parameter int N = 4
) (
  input  logic         i_clk,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_commit,
  input  logic         i_replay,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(N + 1);

  logic [W-1:0]  r_mem [N];
  logic [IW-1:0] r_wr;
  logic [IW-1:0] r_cm;
  logic [IW-1:0] r_rd;
  logic [CW-1:0] r_cnt_all;
  logic [CW-1:0] r_cnt_cm;

  logic          w_push;
  logic          w_pop;
  logic [IW-1:0] w_wr_nxt;
  logic [IW-1:0] w_rd_nxt;
  logic [CW-1:0] w_cnt_all_nxt;
  logic [CW-1:0] w_cnt_cm_nxt;

  function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
    return (p == IW'(N - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full        = (r_cnt_all == CW'(N));
  assign o_data        = r_mem[r_rd];
  assign w_push        = i_push & ~o_full;
  assign w_pop         = i_pop & (r_cnt_cm != '0);
  assign w_wr_nxt      = w_push ? ptr_inc(r_wr) : r_wr;
  assign w_rd_nxt      = w_pop ? ptr_inc(r_rd) : r_rd;
  assign w_cnt_all_nxt = r_cnt_all + CW'(w_push) - CW'(w_pop);
  assign w_cnt_cm_nxt  = r_cnt_cm - CW'(w_pop);

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_flush) begin
      r_wr      <= '0;
      r_cm      <= '0;
      r_rd      <= '0;
      r_cnt_all <= '0;
      r_cnt_cm  <= '0;
    end else begin
      r_rd <= w_rd_nxt;
      // Commit includes this cycle's push; replay rewinds the writer to the commit point.
      if (i_commit) begin
        r_wr      <= w_wr_nxt;
        r_cm      <= w_wr_nxt;
        r_cnt_all <= w_cnt_all_nxt;
        r_cnt_cm  <= w_cnt_all_nxt;
      end else if (i_replay) begin
        r_wr      <= r_cm;
        r_cnt_all <= w_cnt_cm_nxt;
        r_cnt_cm  <= w_cnt_cm_nxt;
      end else begin
        r_wr      <= w_wr_nxt;
        r_cnt_all <= w_cnt_all_nxt;
        r_cnt_cm  <= w_cnt_cm_nxt;
      end
    end
  end
endmodule

// File: rtl/ob_host_if.sv
// Host-side initiator for the order-book engine: stamps commands with uids, limits
// in-flight commands, checks response ordering and buffers responses for the host.
module ob_host_if
  import ob_pkg::*;
#(
  parameter int MAX_OUTSTANDING = cfg_pkg::HOST_MAX_OUTSTANDING,
  parameter int UID_W           = ob_pkg::UID_W
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               host_req_vld,
  input  cmd_t                               host_req,
  output logic                               host_req_rdy,
  output logic [UID_W-1:0]                   host_req_uid,
  output logic                               cmd_vld_r,
  output cmd_t                               cmd_r,
  input  logic                               cmd_full_r,
  input  logic                               rsp_vld,
  input  rsp_t                               rsp,
  output logic                               rsp_accept,
  output logic                               host_rsp_vld_r,
  output rsp_t                               host_rsp_r,
  input  logic                               host_rsp_rdy,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_r,
  output logic                               err_uid_r,
  output logic                               err_spurious_r
);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  // Handshakes: a transfer happens in any cycle where valid and ready/accept are both
  // high; valid never waits on ready, and ready depends only on registered state.
  logic [UID_W-1:0] r_uid_ctr;
  logic [UID_W-1:0] w_trk_head;
  logic             w_trk_full;
  logic             w_accept;
  logic             w_pop;
  logic             w_spurious;
  cmd_t             w_cmd;

  assign host_req_rdy = ~cmd_full_r & (outstanding_r < OW'(MAX_OUTSTANDING)) & ~w_trk_full;
  assign host_req_uid = r_uid_ctr;
  assign w_accept     = host_req_vld & host_req_rdy;
  assign rsp_accept   = rsp_vld & (~host_rsp_vld_r | host_rsp_rdy);
  assign w_pop        = rsp_accept & (outstanding_r != '0);
  assign w_spurious   = rsp_accept & (outstanding_r == '0);

  always_comb begin
    w_cmd     = host_req;
    w_cmd.uid = uid_t'(r_uid_ctr);
  end

  libv_queue #(
    .W (UID_W),
    .N (MAX_OUTSTANDING)
  ) u_trk (
    .i_clk    (clk),
    .i_flush  (~rst),
    .i_push   (w_accept),
    .i_data   (r_uid_ctr),
    .i_commit (w_accept),
    .i_replay (1'b0),
    .i_pop    (w_pop),
    .o_data   (w_trk_head),
    .o_full   (w_trk_full)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_uid_ctr      <= '0;
      cmd_vld_r      <= 1'b0;
      cmd_r          <= '0;
      outstanding_r  <= '0;
      host_rsp_vld_r <= 1'b0;
      host_rsp_r     <= '0;
      err_uid_r      <= 1'b0;
      err_spurious_r <= 1'b0;
    end else begin
      cmd_vld_r <= w_accept;
      if (w_accept) begin
        cmd_r     <= w_cmd;
        r_uid_ctr <= r_uid_ctr + 1'b1;
      end

      case ({w_accept, w_pop})
        2'b10:   outstanding_r <= outstanding_r + 1'b1;
        2'b01:   outstanding_r <= outstanding_r - 1'b1;
        default: outstanding_r <= outstanding_r;
      endcase

      // A simultaneous host take and new accept keeps the stage full with new data.
      if (rsp_accept) begin
        host_rsp_r     <= rsp;
        host_rsp_vld_r <= 1'b1;
      end else if (host_rsp_rdy) begin
        host_rsp_vld_r <= 1'b0;
      end

      if (w_pop && (rsp.uid != uid_t'(w_trk_head))) err_uid_r <= 1'b1;
      if (w_spurious) err_spurious_r <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ob_host_if.sv
// Bench for ob_host_if: directed scenarios plus a randomized phase, checked against a
// transaction-level model (queue of issued uids, host output stage, sticky flags).
module tb_ob_host_if;
  import ob_pkg::*;

  localparam int MAXO = 4;
  localparam int NUID = 1 << UID_W;
  localparam int OW   = $clog2(MAXO + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             host_req_vld = 1'b0;
  cmd_t             host_req = '0;
  logic             host_req_rdy;
  logic [UID_W-1:0] host_req_uid;
  logic             cmd_vld_r;
  cmd_t             cmd_r;
  logic             cmd_full_r = 1'b0;
  logic             rsp_vld = 1'b0;
  rsp_t             rsp = '0;
  logic             rsp_accept;
  logic             host_rsp_vld_r;
  rsp_t             host_rsp_r;
  logic             host_rsp_rdy = 1'b0;
  logic [OW-1:0]    outstanding_r;
  logic             err_uid_r;
  logic             err_spurious_r;

  always #5 clk = ~clk;

  ob_host_if #(
    .MAX_OUTSTANDING (MAXO),
    .UID_W           (UID_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .host_req_vld   (host_req_vld),
    .host_req       (host_req),
    .host_req_rdy   (host_req_rdy),
    .host_req_uid   (host_req_uid),
    .cmd_vld_r      (cmd_vld_r),
    .cmd_r          (cmd_r),
    .cmd_full_r     (cmd_full_r),
    .rsp_vld        (rsp_vld),
    .rsp            (rsp),
    .rsp_accept     (rsp_accept),
    .host_rsp_vld_r (host_rsp_vld_r),
    .host_rsp_r     (host_rsp_r),
    .host_rsp_rdy   (host_rsp_rdy),
    .outstanding_r  (outstanding_r),
    .err_uid_r      (err_uid_r),
    .err_spurious_r (err_spurious_r)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [UID_W-1:0] exp_q[$];
  int               m_uid;
  bit               m_cmd_vld;
  cmd_t             m_cmd;
  bit               m_hv;
  rsp_t             m_hr;
  bit               m_eu;
  bit               m_es;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic cmd_t rnd_cmd();
    logic [$bits(cmd_t)-1:0] v;
    v = $bits(cmd_t)'({$urandom(), $urandom()});
    return cmd_t'(v);
  endfunction

  function automatic rsp_t mk_rsp(input logic [UID_W-1:0] uid);
    rsp_t r;
    r.uid    = uid;
    r.status = status_e'($urandom_range(0, 3));
    r.qty    = 16'($urandom());
    return r;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_uid     = 0;
    m_cmd_vld = 1'b0;
    m_cmd     = '0;
    m_hv      = 1'b0;
    m_hr      = '0;
    m_eu      = 1'b0;
    m_es      = 1'b0;
  endtask

  task automatic check_regs();
    chk("cmd_vld_r", 64'(cmd_vld_r), 64'(m_cmd_vld));
    if (m_cmd_vld) chk("cmd_r", 64'(cmd_r), 64'(m_cmd));
    chk("host_rsp_vld_r", 64'(host_rsp_vld_r), 64'(m_hv));
    if (m_hv) chk("host_rsp_r", 64'(host_rsp_r), 64'(m_hr));
    chk("outstanding_r", 64'(outstanding_r), 64'(exp_q.size()));
    chk("err_uid_r", 64'(err_uid_r), 64'(m_eu));
    chk("err_spurious_r", 64'(err_spurious_r), 64'(m_es));
    chk("host_req_uid", 64'(host_req_uid), 64'(m_uid));
  endtask

  // Reset is applied with traffic on the inputs to show it dominates.
  task automatic do_reset();
    host_req_vld = 1'b1;
    host_req     = rnd_cmd();
    rsp_vld      = 1'b1;
    rsp          = mk_rsp(UID_W'($urandom()));
    host_rsp_rdy = 1'b0;
    cmd_full_r   = 1'b0;
    rst          = 1'b0;
    @(posedge clk);
    #1;
    chk("rst cmd_vld_r", 64'(cmd_vld_r), 64'd0);
    chk("rst cmd_r", 64'(cmd_r), 64'd0);
    chk("rst host_rsp_vld_r", 64'(host_rsp_vld_r), 64'd0);
    chk("rst host_rsp_r", 64'(host_rsp_r), 64'd0);
    chk("rst outstanding_r", 64'(outstanding_r), 64'd0);
    chk("rst err_uid_r", 64'(err_uid_r), 64'd0);
    chk("rst err_spurious_r", 64'(err_spurious_r), 64'd0);
    chk("rst host_req_uid", 64'(host_req_uid), 64'd0);
    model_reset();
    rst          = 1'b1;
    host_req_vld = 1'b0;
    rsp_vld      = 1'b0;
  endtask

  // One clock: drive inputs, check the combinational handshakes, advance the model,
  // then check registered outputs just after the edge.
  task automatic step(input bit req_v, input cmd_t req, input bit full,
                      input bit rv, input rsp_t r, input bit hrdy);
    bit   exp_rdy;
    bit   exp_acc;
    cmd_t c;
    host_req_vld = req_v;
    host_req     = req;
    cmd_full_r   = full;
    rsp_vld      = rv;
    rsp          = r;
    host_rsp_rdy = hrdy;
    #1;
    exp_rdy = !full && (exp_q.size() < MAXO);
    exp_acc = rv && (!m_hv || hrdy);
    chk("host_req_rdy", 64'(host_req_rdy), 64'(exp_rdy));
    chk("rsp_accept", 64'(rsp_accept), 64'(exp_acc));

    if (exp_acc) begin
      if (exp_q.size() > 0) begin
        if (exp_q.pop_front() != r.uid) m_eu = 1'b1;
      end else begin
        m_es = 1'b1;
      end
      m_hv = 1'b1;
      m_hr = r;
    end else if (hrdy) begin
      m_hv = 1'b0;
    end

    if (req_v && exp_rdy) begin
      c         = req;
      c.uid     = m_uid[UID_W-1:0];
      m_cmd     = c;
      m_cmd_vld = 1'b1;
      exp_q.push_back(m_uid[UID_W-1:0]);
      m_uid     = (m_uid + 1) % NUID;
    end else begin
      m_cmd_vld = 1'b0;
    end

    @(posedge clk);
    #1;
    check_regs();
  endtask

  initial begin
    model_reset();
    do_reset();

    // Idle after reset: ready, uid 0, nothing in flight.
    step(0, '0, 0, 0, '0, 0);
    step(0, '0, 0, 0, '0, 0);

    // Four back-to-back issues, a fifth held, then one answer reopens the window.
    for (int i = 0; i < 5; i++) step(1, rnd_cmd(), 0, 0, '0, 1);
    step(1, rnd_cmd(), 0, 1, mk_rsp(4'd0), 1);
    step(1, rnd_cmd(), 0, 0, '0, 1);
    for (int i = 0; i < 8 && exp_q.size() > 0; i++) step(0, '0, 0, 1, mk_rsp(exp_q[0]), 1);
    step(0, '0, 0, 0, '0, 1);

    // Host back-pressure: first response parks, the rest stall until the host takes.
    do_reset();
    for (int i = 0; i < 4; i++) step(1, rnd_cmd(), 0, 0, '0, 0);
    for (int cyc = 0; cyc < 12 && exp_q.size() > 0; cyc++)
      step(0, '0, 0, 1, mk_rsp(exp_q[0]), cyc >= 3);
    step(0, '0, 0, 0, '0, 1);

    // Out-of-order uid: 5 arrives when 2 is oldest.
    do_reset();
    for (int i = 0; i < 3; i++) step(1, rnd_cmd(), 0, 0, '0, 1);
    step(0, '0, 0, 1, mk_rsp(exp_q[0]), 1);
    step(0, '0, 0, 1, mk_rsp(exp_q[0]), 1);
    step(0, '0, 0, 1, mk_rsp(4'd5), 1);
    step(0, '0, 0, 0, '0, 1);
    step(0, '0, 0, 0, '0, 1);

    // Spurious response with nothing outstanding.
    step(0, '0, 0, 1, mk_rsp(4'd7), 0);
    step(0, '0, 0, 0, '0, 0);
    step(0, '0, 0, 0, '0, 1);

    // uid wrap: issue/answer past 2^UID_W.
    do_reset();
    for (int i = 0; i < NUID + 2; i++) begin
      step(1, rnd_cmd(), 0, 0, '0, 1);
      step(0, '0, 0, 1, mk_rsp(exp_q[0]), 1);
    end

    // Randomized traffic with in-order engine answers and occasional ingress-full.
    for (int i = 0; i < 400; i++) begin
      bit               rv;
      logic [UID_W-1:0] ru;
      rv = (exp_q.size() > 0) && ($urandom_range(0, 2) != 0);
      ru = (exp_q.size() > 0) ? exp_q[0] : '0;
      step($urandom_range(0, 1) == 1, rnd_cmd(), $urandom_range(0, 4) == 0,
           rv, mk_rsp(ru), $urandom_range(0, 3) != 0);
    end

    // Reset in the middle of a burst.
    step(1, rnd_cmd(), 0, 0, '0, 0);
    step(1, rnd_cmd(), 0, 1, mk_rsp(exp_q.size() > 0 ? exp_q[0] : 4'd0), 0);
    do_reset();
    step(0, '0, 0, 0, '0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
